// File: rtl/led_pkg.sv
// Shared definitions for the RGB status LED path (breathing envelope and PWM stage).
package led_pkg;

  localparam int DUTY_W = 16;
  localparam logic [DUTY_W-1:0] LEVEL_MAX = 16'hFFFF;

  typedef enum logic [2:0] {
    ST_OFF       = 3'd0,
    ST_RISE      = 3'd1,
    ST_HOLD_HIGH = 3'd2,
    ST_FALL      = 3'd3,
    ST_HOLD_LOW  = 3'd4
  } led_state_t;

endpackage

// File: rtl/led_duty_scale.sv
// Scales one colour word by the breathing level: (color * (level + 1)) >> 16.
// Purely combinational; the parent registers the result.
module led_duty_scale
  import led_pkg::*;
(
  input  logic [DUTY_W-1:0] color,
  input  logic [DUTY_W-1:0] level,
  output logic [DUTY_W-1:0] duty
);

  logic [DUTY_W:0]   level_p1;
  logic [2*DUTY_W:0] product;

  // level + 1 makes full level map exactly onto the colour word and zero onto zero
  assign level_p1 = (DUTY_W+1)'(level) + (DUTY_W+1)'(1);
  assign product  = (2*DUTY_W+1)'(color) * (2*DUTY_W+1)'(level_p1);
  assign duty     = DUTY_W'(product >> DUTY_W);

endmodule

// File: rtl/led_breathe_seq.sv
// Breathing envelope for the RGB status LED: rise/hold/fall/hold level FSM,
// colour shadows and per-channel registered duty words, all advanced on PWM wraps.
module led_breathe_seq
  import led_pkg::*;
#(
  parameter int STEP_W = 16,
  parameter int HOLD_W = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              enable,
  input  logic              period_wrap,
  input  logic [15:0]       color_r,
  input  logic [15:0]       color_g,
  input  logic [15:0]       color_b,
  input  logic [STEP_W-1:0] rise_step,
  input  logic [STEP_W-1:0] fall_step,
  input  logic [HOLD_W-1:0] hold_high,
  input  logic [HOLD_W-1:0] hold_low,
  output logic [15:0]       red_duty,
  output logic [15:0]       green_duty,
  output logic [15:0]       blue_duty,
  output logic [2:0]        phase,
  output logic              cycle_done
);

  localparam int SUM_W = ((STEP_W > DUTY_W) ? STEP_W : DUTY_W) + 1;

  led_state_t        state_q, state_d;
  logic [DUTY_W-1:0] level_q, level_d;
  logic [HOLD_W-1:0] cnt_q, cnt_d;
  logic              done_d;
  logic [DUTY_W-1:0] shadow_r, shadow_g, shadow_b;
  logic [DUTY_W-1:0] scaled_r, scaled_g, scaled_b;

  logic [SUM_W-1:0]  rise_sum;
  logic [SUM_W-1:0]  level_wide;
  logic [SUM_W-1:0]  fall_wide;
  logic [DUTY_W-1:0] rise_sat;
  logic [DUTY_W-1:0] fall_sat;

  // Saturating level arithmetic, widened so wide step inputs cannot wrap
  assign level_wide = SUM_W'(level_q);
  assign fall_wide  = SUM_W'(fall_step);
  assign rise_sum   = level_wide + SUM_W'(rise_step);
  assign rise_sat   = (rise_sum > SUM_W'(LEVEL_MAX)) ? LEVEL_MAX : DUTY_W'(rise_sum);
  assign fall_sat   = (level_wide > fall_wide) ? DUTY_W'(level_wide - fall_wide) : '0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_OFF;
      level_q    <= '0;
      cnt_q      <= '0;
      cycle_done <= 1'b0;
      shadow_r   <= '0;
      shadow_g   <= '0;
      shadow_b   <= '0;
      red_duty   <= '0;
      green_duty <= '0;
      blue_duty  <= '0;
    end else begin
      state_q    <= state_d;
      level_q    <= level_d;
      cnt_q      <= cnt_d;
      cycle_done <= done_d;
      if (period_wrap) begin
        shadow_r <= color_r;
        shadow_g <= color_g;
        shadow_b <= color_b;
      end
      red_duty   <= scaled_r;
      green_duty <= scaled_g;
      blue_duty  <= scaled_b;
    end
  end

  // Everything advances only on a wrap; dropping enable diverts to FALL without a level step
  always_comb begin
    state_d = state_q;
    level_d = level_q;
    cnt_d   = cnt_q;
    done_d  = 1'b0;
    if (period_wrap) begin
      case (state_q)
        ST_OFF: begin
          level_d = '0;
          if (enable) state_d = ST_RISE;
        end
        ST_RISE: begin
          if (!enable) begin
            state_d = ST_FALL;
          end else begin
            level_d = rise_sat;
            if (rise_sat == LEVEL_MAX) begin
              state_d = ST_HOLD_HIGH;
              cnt_d   = hold_high;
            end
          end
        end
        ST_HOLD_HIGH: begin
          if (!enable || cnt_q == '0) state_d = ST_FALL;
          else                        cnt_d   = cnt_q - HOLD_W'(1);
        end
        ST_FALL: begin
          level_d = fall_sat;
          if (fall_sat == '0) begin
            if (enable) begin
              state_d = ST_HOLD_LOW;
              cnt_d   = hold_low;
            end else begin
              state_d = ST_OFF;
            end
          end
        end
        ST_HOLD_LOW: begin
          if (!enable) begin
            state_d = ST_FALL;
          end else if (cnt_q == '0) begin
            state_d = ST_RISE;
            done_d  = 1'b1;
          end else begin
            cnt_d = cnt_q - HOLD_W'(1);
          end
        end
        default: state_d = ST_OFF;
      endcase
    end
  end

  assign phase = state_q;

  led_duty_scale u_scale_r (.color(shadow_r), .level(level_q), .duty(scaled_r));
  led_duty_scale u_scale_g (.color(shadow_g), .level(level_q), .duty(scaled_g));
  led_duty_scale u_scale_b (.color(shadow_b), .level(level_q), .duty(scaled_b));

endmodule

// File: tb/tb_led_breathe_seq.sv
// Bench for led_breathe_seq: directed breathing scenarios then randomized wraps,
// all checked against a behavioural envelope model.
module tb_led_breathe_seq;

  localparam int STEP_W = 16;
  localparam int HOLD_W = 16;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              enable;
  logic              period_wrap;
  logic [15:0]       color_r, color_g, color_b;
  logic [STEP_W-1:0] rise_step, fall_step;
  logic [HOLD_W-1:0] hold_high, hold_low;
  logic [15:0]       red_duty, green_duty, blue_duty;
  logic [2:0]        phase;
  logic              cycle_done;

  int tests_run    = 0;
  int tests_failed = 0;
  int done_count   = 0;

  // Reference envelope: phase number, level and remaining hold periods
  int m_phase, m_level, m_cnt, m_done;
  int m_r, m_g, m_b;

  led_breathe_seq #(.STEP_W(STEP_W), .HOLD_W(HOLD_W)) dut (
    .clk(clk), .rst_n(rst_n), .enable(enable), .period_wrap(period_wrap),
    .color_r(color_r), .color_g(color_g), .color_b(color_b),
    .rise_step(rise_step), .fall_step(fall_step),
    .hold_high(hold_high), .hold_low(hold_low),
    .red_duty(red_duty), .green_duty(green_duty), .blue_duty(blue_duty),
    .phase(phase), .cycle_done(cycle_done)
  );

  always #5 clk = ~clk;

  always @(posedge clk) if (cycle_done === 1'b1) done_count++;

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    tests_run++;
    if (actual !== expected) begin
      tests_failed++;
      $display("[TB] FAIL %s: got %h expected %h", tag, actual, expected);
    end
  endtask

  function automatic int scale(input int color, input int level);
    longint p;
    p = longint'(color) * longint'(level + 1);
    return int'(p / 65536);
  endfunction

  function automatic void model_reset();
    m_phase = 0; m_level = 0; m_cnt = 0; m_done = 0;
    m_r = 0; m_g = 0; m_b = 0;
  endfunction

  // One wrap of the breathing rules, in plain integer arithmetic
  function automatic void model_wrap();
    m_done = 0;
    if (m_phase == 0) begin
      m_level = 0;
      if (enable) m_phase = 1;
    end else if (!enable && m_phase != 3) begin
      m_phase = 3;
    end else if (m_phase == 1) begin
      m_level = m_level + int'(rise_step);
      if (m_level >= 65535) begin
        m_level = 65535;
        m_phase = 2;
        m_cnt   = int'(hold_high);
      end
    end else if (m_phase == 2) begin
      if (m_cnt == 0) m_phase = 3;
      else            m_cnt--;
    end else if (m_phase == 3) begin
      m_level = m_level - int'(fall_step);
      if (m_level <= 0) begin
        m_level = 0;
        if (enable) begin
          m_phase = 4;
          m_cnt   = int'(hold_low);
        end else begin
          m_phase = 0;
        end
      end
    end else begin
      if (m_cnt == 0) begin
        m_phase = 1;
        m_done  = 1;
      end else begin
        m_cnt--;
      end
    end
    m_r = int'(color_r); m_g = int'(color_g); m_b = int'(color_b);
  endfunction

  // Issue one wrap event (period_wrap high for 1 or 2 cycles) and check T+1 and T+2
  task automatic applyStimulus(input int wrap_cycles);
    int pr, pg, pb;
    pr = scale(m_r, m_level);
    pg = scale(m_g, m_level);
    pb = scale(m_b, m_level);
    @(negedge clk);
    period_wrap = 1'b1;
    for (int i = 0; i < wrap_cycles; i++) begin
      @(posedge clk);
      model_wrap();
    end
    #1;
    period_wrap = 1'b0;
    checkOutput("phase", 32'(phase), 32'(m_phase));
    checkOutput("cycle_done_t1", 32'(cycle_done), 32'(m_done));
    if (wrap_cycles == 1) begin
      checkOutput("red_hold_t1", 32'(red_duty), 32'(pr));
      checkOutput("green_hold_t1", 32'(green_duty), 32'(pg));
      checkOutput("blue_hold_t1", 32'(blue_duty), 32'(pb));
    end
    @(posedge clk);
    #1;
    checkOutput("cycle_done_t2", 32'(cycle_done), 32'd0);
    checkOutput("red_duty", 32'(red_duty), 32'(scale(m_r, m_level)));
    checkOutput("green_duty", 32'(green_duty), 32'(scale(m_g, m_level)));
    checkOutput("blue_duty", 32'(blue_duty), 32'(scale(m_b, m_level)));
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
  endtask

  task automatic check_all_zero(input string tag);
    checkOutput({tag, "_red"}, 32'(red_duty), 32'd0);
    checkOutput({tag, "_green"}, 32'(green_duty), 32'd0);
    checkOutput({tag, "_blue"}, 32'(blue_duty), 32'd0);
    checkOutput({tag, "_phase"}, 32'(phase), 32'd0);
    checkOutput({tag, "_done"}, 32'(cycle_done), 32'd0);
  endtask

  // Assert reset between clock edges and check the outputs clear without a clock
  task automatic async_reset();
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    check_all_zero("async_reset");
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    int base;
    int sel;
    rst_n = 1'b0; enable = 1'b0; period_wrap = 1'b0;
    color_r = '0; color_g = '0; color_b = '0;
    rise_step = '0; fall_step = '0; hold_high = '0; hold_low = '0;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    check_all_zero("reset");
    @(negedge clk);
    rst_n = 1'b1;

    // Ramp up in quarter steps to full
    color_r = 16'hFFFF; color_g = 16'h7530; color_b = 16'h0000;
    enable = 1'b1; rise_step = 16'h4000; hold_high = '0;
    fall_step = 16'h8000; hold_low = 16'd2;
    repeat (5) begin applyStimulus(1); idle(12); end
    checkOutput("full_red", 32'(red_duty), 32'h0000FFFF);
    checkOutput("full_green", 32'(green_duty), 32'h00007530);
    checkOutput("full_blue", 32'(blue_duty), 32'h0);
    checkOutput("full_phase", 32'(phase), 32'd2);

    // Fall, three periods at zero, then one cycle_done pulse into RISE
    base = done_count;
    repeat (3) begin applyStimulus(1); idle(12); end
    checkOutput("enter_hold_low", 32'(phase), 32'd4);
    repeat (2) begin applyStimulus(1); idle(12); end
    checkOutput("still_hold_low", 32'(phase), 32'd4);
    applyStimulus(1);
    checkOutput("back_to_rise", 32'(phase), 32'd1);
    idle(5);
    checkOutput("done_pulses", 32'(done_count - base), 32'd1);

    // Drop enable while holding high
    hold_high = 16'd5;
    repeat (4) begin applyStimulus(1); idle(3); end
    applyStimulus(1);
    enable = 1'b0;
    applyStimulus(1);
    checkOutput("disable_to_fall", 32'(phase), 32'd3);
    repeat (2) begin applyStimulus(1); idle(3); end
    check_all_zero("faded_off");

    // Colour write mid-period is shadowed until the next wrap
    enable = 1'b1; rise_step = 16'hFFFF; hold_high = 16'd20;
    applyStimulus(1);
    applyStimulus(1);
    idle(4);
    @(negedge clk);
    color_r = 16'h1000;
    idle(6);
    checkOutput("red_shadowed", 32'(red_duty), 32'h0000FFFF);
    applyStimulus(1);
    checkOutput("red_new_colour", 32'(red_duty), 32'h00001000);

    // Async reset in the middle of a fall
    enable = 1'b0; fall_step = 16'h1000;
    applyStimulus(1);
    applyStimulus(1);
    checkOutput("mid_fall", 32'(phase), 32'd3);
    async_reset();
    idle(3);
    check_all_zero("after_reset");

    // Zero rise step stalls without locking up
    enable = 1'b1; rise_step = 16'h2000;
    applyStimulus(1);
    applyStimulus(1);
    rise_step = '0;
    repeat (4) applyStimulus(1);
    checkOutput("stalled_rise", 32'(phase), 32'd1);
    rise_step = 16'hFFFF;
    applyStimulus(1);
    checkOutput("unstalled", 32'(phase), 32'd2);

    // Randomized operation, including double-cycle wraps and occasional resets
    for (int it = 0; it < 300; it++) begin
      @(negedge clk);
      enable = ($urandom_range(0, 99) < 85);
      if ($urandom_range(0, 3) == 0) begin
        color_r = 16'($urandom); color_g = 16'($urandom); color_b = 16'($urandom);
      end
      if ($urandom_range(0, 3) == 0) begin
        sel = $urandom_range(0, 4);
        rise_step = (sel == 0) ? 16'h0 : (sel == 1) ? 16'hFFFF : (sel == 2) ? 16'h4000 : 16'($urandom);
        sel = $urandom_range(0, 4);
        fall_step = (sel == 0) ? 16'h0 : (sel == 1) ? 16'hFFFF : (sel == 2) ? 16'h8000 : 16'($urandom);
        hold_high = 16'($urandom_range(0, 3));
        hold_low  = 16'($urandom_range(0, 3));
      end
      applyStimulus(($urandom_range(0, 9) == 0) ? 2 : 1);
      idle($urandom_range(0, 6));
      if ($urandom_range(0, 99) == 0) async_reset();
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
